md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the E stage of the pipelined MIPS CPU. It accepts the MD-class instructions (mult, multu, div, divu, madd, mthi, mtlo), runs each computing operation for a fixed number of cycles, and owns the HI/LO registers. It drives the D-stage stall for any MD-type instruction that arrives while an operation is running.

---
 rtl/md_sequencer.sv | 148 ++++++++++++++
 tb/tb_md_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// ============================================================================
//  Module      : md_sequencer
//  Description : Multi-cycle multiply/divide sequencer for the E stage.
//                Owns HI/LO, runs mult/multu/madd/div/divu for a fixed
//                cycle count and drives the D-stage stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_in_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = ($clog2(C_MAX_CYCLES + 1) < 4) ? 4 : $clog2(C_MAX_CYCLES + 1);

    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;
    localparam logic [2:0] C_OP_MADD  = 3'd6;

    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MULT = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_DIV  = C_CNT_W'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [2:0]           r_op;

    logic                 w_comp_op;
    logic                 w_last;
    logic                 w_start;
    logic [C_CNT_W-1:0]   w_start_cnt;
    logic [63:0]          w_sprod;
    logic [63:0]          w_uprod;
    logic [31:0]          w_abs_a;
    logic [31:0]          w_abs_b;
    logic [31:0]          w_sden;
    logic [31:0]          w_uden;
    logic [31:0]          w_mag_q;
    logic [31:0]          w_mag_r;
    logic [31:0]          w_squo;
    logic [31:0]          w_srem;
    logic [63:0]          w_res;

    // Decode incoming op class and decide whether a new computation starts this edge
    always_comb begin
        w_comp_op   = (md_op == C_OP_MULT) || (md_op == C_OP_MULTU) || (md_op == C_OP_DIV) ||
                      (md_op == C_OP_DIVU) || (md_op == C_OP_MADD);
        w_last      = (r_state == RUN) && (r_cnt == C_CNT_ONE);
        // A new op may also start on the edge that commits the previous one
        w_start     = md_valid && w_comp_op && ((r_state == IDLE) || w_last);
        w_start_cnt = ((md_op == C_OP_DIV) || (md_op == C_OP_DIVU)) ? C_CNT_DIV : C_CNT_MULT;
    end

    // Result datapath from the latched operands; divide by zero leaves HI/LO as they are
    always_comb begin
        w_sprod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
        w_uprod = {32'd0, r_a} * {32'd0, r_b};
        w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
        w_abs_b = r_b[31] ? (32'd0 - r_b) : r_b;
        // Divisors are forced non-zero so the dividers never see 0; that case is masked below
        w_sden  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
        w_uden  = (r_b == 32'd0) ? 32'd1 : r_b;
        w_mag_q = w_abs_a / w_sden;
        w_mag_r = w_abs_a % w_sden;
        // Quotient truncates toward zero, remainder follows the dividend's sign;
        // 0x80000000 / -1 wraps back to 0x80000000 through the negation
        w_squo  = (r_a[31] ^ r_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
        w_srem  = r_a[31] ? (32'd0 - w_mag_r) : w_mag_r;
        w_res   = {hi, lo};
        case (r_op)
            C_OP_MULT:  w_res = w_sprod;
            C_OP_MULTU: w_res = w_uprod;
            C_OP_MADD:  w_res = {hi, lo} + w_sprod;
            C_OP_DIV:   if (r_b != 32'd0) w_res = {w_srem, w_squo};
            C_OP_DIVU:  if (r_b != 32'd0) w_res = {r_a % w_uden, r_a / w_uden};
            default:    w_res = {hi, lo};
        endcase
    end

    // Sequencer FSM: accepts ops, counts down, commits HI/LO, handles mthi/mtlo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            if (r_state == RUN) begin
                if (w_last) begin
                    {hi, lo} <= w_res;
                    r_state  <= IDLE;
                    busy     <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - C_CNT_ONE;
                end
            end else if (md_valid) begin
                if (md_op == C_OP_MTHI) hi <= a;
                if (md_op == C_OP_MTLO) lo <= a;
            end
            // Placed last so a back-to-back start overrides the return to IDLE
            if (w_start) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= md_op;
                r_cnt   <= w_start_cnt;
                r_state <= RUN;
                busy    <= 1'b1;
            end
        end
    end

    // Hold MD-type instructions in D while a computation is running or about to start
    always_comb begin
        stall = md_in_d && (busy || (md_valid && w_comp_op));
    end

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
//  Module      : tb_md_sequencer
//  Description : Directed self-checking bench for md_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int passed = 0;
    int total  = 0;

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_in_d  (md_in_d),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one computing op, check busy/stall each cycle and the committed result
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        md_valid = 1'b1;
        md_op    = op;
        a        = va;
        b        = vb;
        #1;
        chk({tag, " stall_accept"}, {31'd0, stall}, {31'd0, md_in_d});
        tick();
        md_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " stall_busy"}, {31'd0, stall}, {31'd0, md_in_d});
            tick();
        end
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, " stall_end"}, {31'd0, stall}, 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    // Single-edge mthi/mtlo write
    task automatic move(input logic [2:0] op, input logic [31:0] va);
        md_valid = 1'b1;
        md_op    = op;
        a        = va;
        tick();
        md_valid = 1'b0;
        chk("move busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        md_valid = 1'b0;
        md_op    = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        md_in_d  = 1'b1;
        #12;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        reset   = 1'b0;
        md_in_d = 1'b0;
        tick();

        // Signed and unsigned multiply, no D-stage MD instruction so no stall
        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // Divides with a waiting MD instruction in D: stall for accept + 10 busy cycles
        md_in_d = 1'b1;
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_in_d = 1'b0;
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // mthi/mtlo then madd accumulates into them
        move(3'd4, 32'h1234_5678);
        chk("mthi hi", hi, 32'h1234_5678);
        move(3'd5, 32'hFFFF_FFFF);
        chk("mtlo lo", lo, 32'hFFFF_FFFF);
        run_op("madd", 3'd6, 32'd3, 32'd4, 5, 32'h1234_5679, 32'h0000_000B);

        // Reserved op 7 does nothing
        move(3'd7, 32'h5555_5555);
        chk("op7 hi", hi, 32'h1234_5679);
        chk("op7 lo", lo, 32'h0000_000B);

        // md_valid during RUN is ignored
        md_valid = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd5;
        tick();
        md_valid = 1'b0;
        tick();
        md_valid = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd1;
        tick();
        md_valid = 1'b0;
        tick();
        tick();
        chk("ignore busy_t4", {31'd0, busy}, 32'd1);
        tick();
        chk("ignore busy_t5", {31'd0, busy}, 32'd0);
        chk("ignore hi", hi, 32'd0);
        chk("ignore lo", lo, 32'd15);
        tick();
        chk("ignore no_restart", {31'd0, busy}, 32'd0);
        chk("ignore lo_hold", lo, 32'd15);

        // Divide by zero keeps HI/LO
        move(3'd4, 32'h0000_00AA);
        move(3'd5, 32'h0000_00BB);
        run_op("div0", 3'd2, 32'd5, 32'd0, 10, 32'h0000_00AA, 32'h0000_00BB);

        // Back-to-back: second op accepted on the commit edge of the first
        md_valid = 1'b1; md_op = 3'd0; a = 32'd2; b = 32'd3;
        tick();
        md_valid = 1'b0;
        repeat (4) tick();
        md_valid = 1'b1; md_op = 3'd1; a = 32'd4; b = 32'd5;
        tick();
        md_valid = 1'b0;
        chk("b2b first lo", lo, 32'd6);
        chk("b2b first hi", hi, 32'd0);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("b2b busy_t4", {31'd0, busy}, 32'd1);
        tick();
        chk("b2b second lo", lo, 32'd20);
        chk("b2b busy_end", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a mult: immediate clear, no commit later
        md_valid = 1'b1; md_op = 3'd0; a = 32'd7; b = 32'd9;
        tick();
        md_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("abort late_lo", lo, 32'd0);
        chk("abort late_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
